data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Load/store unit between the single-cycle datapath's data-memory port and a word-wide synchronous data RAM.
//  Converts byte/half/word loads and stores (RV32I func3) into byte-enabled word accesses.
//  Sign/zero-extends load data and stalls the core for the RAM's multi-cycle latency.
//  Flags misaligned or illegal accesses on rsp_err.
// PARAMETERS
//  ADDR_WIDTH   10  RAM word-address bits; mem_addr = req_addr[ADDR_WIDTH+1:2]
//  WAIT_STATES  1   extra RAM read-latency cycles after the first access cycle (0..15)
// PORTS
//  clk        in   1           core clock, rising edge
//  reset_n    in   1           asynchronous, active-low reset
//  req_valid  in   1           load/store request; held with all req_* stable while stall=1
//  req_we     in   1           1=store, 0=load
//  req_func3  in   3           RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
//  req_addr   in   32          byte address (ALU result)
//  req_wdata  in   32          store data (rs2), right-justified
//  stall      out  1           hold the core's PC/regfile write this cycle
//  rsp_valid  out  1           one-cycle pulse: transaction complete, rsp_rdata/rsp_err valid
//  rsp_rdata  out  32          extended load data (0 for stores and on error)
//  rsp_err    out  1           misaligned or illegal func3; no RAM access was made
//  mem_en     out  1           RAM access strobe, one cycle per transaction
//  mem_we     out  1           RAM write enable (qualified by mem_en)
//  mem_be     out  4           byte enables; bit i = byte lane i
//  mem_addr   out  ADDR_WIDTH  RAM word address
//  mem_wdata  out  32          lane-replicated store data
//  mem_rdata  in   32          RAM read data, valid WAIT_STATES+1 cycles after mem_en
// BEHAVIOUR
//  Reset: async on reset_n low.
//   - state=IDLE; wait counter=0.
//   - All outputs 0, except stall, which follows req_valid combinationally.
//   - Reset mid-transaction abandons it: no rsp_valid; mem_en drops immediately.
//  FSM states: IDLE, ACCESS, WAIT, DONE.
//   - IDLE: req_valid=1 latches the req_* fields. Next state is ACCESS if the request is legal, else DONE with err.
//   - ACCESS: mem_en=1 for exactly one cycle.
//     - Store goes to DONE.
//     - Load goes to WAIT if WAIT_STATES>0, else DONE.
//   - WAIT: counts WAIT_STATES cycles, then goes to DONE.
//   - DONE: rsp_valid=1; load data captured from mem_rdata. Next state is IDLE.
//  Outputs:
//   - stall = (IDLE & req_valid) | ACCESS | WAIT; stall is 0 in DONE so the core retires on that edge.
//   - Latency, accept edge to rsp_valid:
//     - legal store: 2 cycles
//     - legal load: 2+WAIT_STATES cycles
//     - error: 1 cycle
//   - A new request is seen only in IDLE; back-to-back accesses therefore cost one IDLE cycle each.
//  Store lanes (o = req_addr[1:0]):
//   - SB: be = 4'b0001<<o; wdata = {4{wdata[7:0]}}
//   - SH: be = 4'b0011<<o; wdata = {2{wdata[15:0]}}
//   - SW: be = 4'hF
//  Loads (mem_be=4'hF, mem_we=0):
//   - LB/LBU: select byte o, sign/zero-extend to 32.
//   - LH/LHU: select half o[1], sign/zero-extend to 32.
//   - LW: pass the word through.
//  Legality:
//   - Loads: func3 in {0,1,2,4,5}.
//   - Stores: func3 in {0,1,2}.
//   - Other codes: rsp_err=1, no mem_en.
//  Alignment: half requires o[0]=0; word requires o=0 (see CONFIGURATION).
//  Address bits above ADDR_WIDTH+1 are ignored (wrap within RAM).
//  rsp_rdata/rsp_err hold their DONE values until the next DONE or reset.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   - A misaligned half/word access gives rsp_err=1, rsp_rdata=0 and no RAM access (1-cycle latency).
//  LSU_MISALIGN_TRAP_EN undefined:
//   - The offending low address bits are forced to 0 (half: o[0]; word: o[1:0]).
//   - The access proceeds normally; rsp_err is set only for illegal func3.
// TESTING
//  1. SW, WAIT_STATES=1: addr 0x8, wdata 0xDEADBEEF -> mem_en 1 cycle, mem_addr=2, be=F, rsp_valid 2 cycles after accept.
//  2. SB then LB/LBU: store 0x80 at 0x5 -> be=0010, wdata=0x80808080; LB 0x5 -> 0xFFFFFF80; LBU 0x5 -> 0x00000080.
//  3. LH at 0x2 with mem_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; LHU -> 0x00008001; stall high exactly 3 cycles.
//  4. LW at 0x6, trap macro on -> rsp_err=1, no mem_en, 1-cycle latency; macro off -> mem_addr=1, be=F, err=0.
//  5. Load func3=3 -> rsp_err=1, no mem_en; store func3=4 -> rsp_err=1.
//  6. reset_n low during WAIT -> mem_en/rsp_valid 0 immediately, state IDLE, no rsp_valid after release.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store unit: RV32I byte/half/word accesses onto a word-wide synchronous RAM with wait states.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise misaligned low address bits are cleared.
module data_mem_lsu #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_func3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              q_we, q_unsigned, q_err;
  logic [1:0]        q_size, q_off;
  logic [31:0]       rdata_q;

  logic [1:0]        size, off, eff_off;
  logic              legal, misaligned, err_now;
  logic [3:0]        be_now;
  logic [31:0]       wdata_now, load_data;
  logic              unused_addr;

  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2]};

  // Request decode: legality, alignment, lane placement of store data.
  always_comb begin
    size       = req_func3[1:0];
    off        = req_addr[1:0];
    legal      = req_we ? (req_func3 inside {3'd0, 3'd1, 3'd2})
                        : (req_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misaligned = ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
    err_now    = !legal || (TRAP_EN && misaligned);
    case (size)
      2'd1:    eff_off = {off[1], 1'b0};
      2'd2:    eff_off = 2'd0;
      default: eff_off = off;
    endcase
    be_now    = 4'hF;
    wdata_now = 32'h0;
    if (req_we) begin
      case (size)
        2'd0: begin be_now = 4'b0001 << eff_off; wdata_now = {4{req_wdata[7:0]}};  end
        2'd1: begin be_now = 4'b0011 << eff_off; wdata_now = {2{req_wdata[15:0]}}; end
        default: wdata_now = req_wdata;
      endcase
    end
  end

  // Load lane select and extension; zero for stores and errors.
  always_comb begin
    load_data = 32'h0;
    if (!q_we && !q_err) begin
      case (q_size)
        2'd0: load_data = q_unsigned ? {24'h0, mem_rdata[8*q_off +: 8]}
                                     : {{24{mem_rdata[8*q_off + 7]}}, mem_rdata[8*q_off +: 8]};
        2'd1: load_data = q_unsigned ? {16'h0, mem_rdata[16*q_off[1] +: 16]}
                                     : {{16{mem_rdata[16*q_off[1] + 15]}}, mem_rdata[16*q_off[1] +: 16]};
        default: load_data = mem_rdata;
      endcase
    end
  end

  // Response data is presented straight from the RAM in DONE, then held.
  assign rsp_rdata = (state == S_DONE) ? load_data : rdata_q;
  assign stall     = ((state == S_IDLE) && req_valid) || (state == S_ACCESS) || (state == S_WAIT);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req_valid) state_next = err_now ? S_DONE : S_ACCESS;
      S_ACCESS: state_next = (q_we || (WAIT_STATES == 0)) ? S_DONE : S_WAIT;
      S_WAIT:   if (wait_cnt == WAIT_LAST) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      q_we       <= 1'b0;
      q_unsigned <= 1'b0;
      q_err      <= 1'b0;
      q_size     <= 2'd0;
      q_off      <= 2'd0;
      rdata_q    <= 32'h0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
    end else begin
      state     <= state_next;
      wait_cnt  <= (state == S_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      mem_en    <= (state_next == S_ACCESS);
      rsp_valid <= (state_next == S_DONE);
      if (state_next == S_DONE) rsp_err <= (state == S_IDLE) ? err_now : 1'b0;
      if (state == S_DONE) rdata_q <= load_data;
      if ((state == S_IDLE) && req_valid) begin
        q_we       <= req_we;
        q_unsigned <= req_func3[2];
        q_err      <= err_now;
        q_size     <= size;
        q_off      <= eff_off;
        if (!err_now) begin
          mem_we    <= req_we;
          mem_be    <= be_now;
          mem_addr  <= req_addr[ADDR_WIDTH+1:2];
          mem_wdata <= wdata_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: directed requests push expected RAM accesses and responses; a monitor checks them.
module tb_data_mem_lsu;
  localparam int unsigned AW = 10;
  localparam int unsigned WS = 1;
  localparam int LD = 2 + WS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_we;
  logic [2:0]    req_func3;
  logic [31:0]   req_addr, req_wdata;
  logic          stall, rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0]   rsp_rdata, mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct packed { logic we; logic [3:0] be; logic [AW-1:0] addr; logic [31:0] wdata; } acc_t;

  rsp_t        rsp_q[$];
  acc_t        acc_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ram [0:(1<<AW)-1];

  data_mem_lsu #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // RAM model: read data appears after the mem_en edge and holds until the next read.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
    end
  end

  // Monitor: every RAM access and every response must match the next queued expectation.
  acc_t ea;
  rsp_t er;
  always @(negedge clk) begin
    if (mem_en) begin
      if (acc_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL mem_access: unexpected mem_en addr=0x%0h be=0x%0h at %0t", mem_addr, mem_be, $time);
      end else begin
        ea = acc_q.pop_front();
        chk("mem_we", 32'(mem_we), 32'(ea.we));
        chk("mem_be", 32'(mem_be), 32'(ea.be));
        chk("mem_addr", 32'(mem_addr), 32'(ea.addr));
        if (ea.we) chk("mem_wdata", mem_wdata, ea.wdata);
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp: unexpected rsp_valid rdata=0x%08h err=%0b at %0t", rsp_rdata, rsp_err, $time);
      end else begin
        er = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, er.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(er.err));
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_acc, input logic [3:0] be, input logic [AW-1:0] maddr,
                        input logic [31:0] mwdata, input int exp_lat);
    int lat;
    int stall_cnt;
    bit got;
    rsp_q.push_back(rsp_t'{exp_rdata, exp_err});
    if (exp_acc) acc_q.push_back(acc_t'{we, be, maddr, mwdata});
    @(posedge clk); #2;
    req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    got = 1'b0; lat = -1; stall_cnt = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; lat = i;
        chk("stall_in_done", 32'(stall), 32'h0);
      end else if (stall) begin
        stall_cnt++;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_lat));
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    ram[0] = 32'h8001_1234;
    reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #3;
    chk("reset_outputs", {rsp_valid, rsp_err, mem_en, mem_we, mem_be, 24'(mem_addr)},
        32'h0);
    chk("reset_rdata_wdata", rsp_rdata | mem_wdata, 32'h0);
    chk("reset_stall_follows_req", 32'(stall), 32'h1);
    req_valid = 1'b0; #1;
    chk("reset_stall_low", 32'(stall), 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;

    // SW / SB / loads
    do_req(1, 3'd2, 32'h8, 32'hDEADBEEF, 32'h0, 0, 1, 4'hF, 10'd2, 32'hDEADBEEF, 2);
    do_req(1, 3'd0, 32'h5, 32'h12345680, 32'h0, 0, 1, 4'b0010, 10'd1, 32'h80808080, 2);
    do_req(0, 3'd0, 32'h5, 32'h0, 32'hFFFFFF80, 0, 1, 4'hF, 10'd1, 32'h0, LD);
    do_req(0, 3'd4, 32'h5, 32'h0, 32'h00000080, 0, 1, 4'hF, 10'd1, 32'h0, LD);
    chk("rdata_hold", rsp_rdata, 32'h00000080);
    do_req(0, 3'd1, 32'h2, 32'h0, 32'hFFFF8001, 0, 1, 4'hF, 10'd0, 32'h0, LD);
    do_req(0, 3'd5, 32'h2, 32'h0, 32'h00008001, 0, 1, 4'hF, 10'd0, 32'h0, LD);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(0, 3'd2, 32'h6, 32'h0, 32'h0, 1, 0, 4'h0, 10'd0, 32'h0, 1);
`else
    do_req(0, 3'd2, 32'h6, 32'h0, 32'h00008000, 0, 1, 4'hF, 10'd1, 32'h0, LD);
`endif
    // Illegal func3
    do_req(0, 3'd3, 32'h0, 32'h0, 32'h0, 1, 0, 4'h0, 10'd0, 32'h0, 1);
    chk("err_hold", 32'(rsp_err), 32'h1);
    do_req(1, 3'd4, 32'h0, 32'h5555, 32'h0, 1, 0, 4'h0, 10'd0, 32'h0, 1);
    // SH upper half, then readbacks
    do_req(1, 3'd1, 32'h6, 32'h0000ABCD, 32'h0, 0, 1, 4'b1100, 10'd1, 32'hABCDABCD, 2);
    do_req(0, 3'd2, 32'h8, 32'h0, 32'hDEADBEEF, 0, 1, 4'hF, 10'd2, 32'h0, LD);
    do_req(0, 3'd0, 32'h7, 32'h0, 32'hFFFFFFAB, 0, 1, 4'hF, 10'd1, 32'h0, LD);
    do_req(0, 3'd5, 32'h4, 32'h0, 32'h00008000, 0, 1, 4'hF, 10'd1, 32'h0, LD);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1, 3'd1, 32'h5, 32'h00001111, 32'h0, 1, 0, 4'h0, 10'd0, 32'h0, 1);
`else
    do_req(1, 3'd1, 32'h5, 32'h00001111, 32'h0, 0, 1, 4'b0011, 10'd1, 32'h11111111, 2);
`endif

    // Reset during WAIT: the access happened, the response must never appear.
    acc_q.push_back(acc_t'{1'b0, 4'hF, 10'd0, 32'h0});
    @(posedge clk); #2;
    req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = 1'b0; #1;
    chk("rst_state_idle", 32'(stall), 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Upper address bits wrap into the RAM
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(0, 3'd2, 32'h10000004, 32'h0, 32'hABCD8000, 0, 1, 4'hF, 10'd1, 32'h0, LD);
`else
    do_req(0, 3'd2, 32'h10000004, 32'h0, 32'hABCD1111, 0, 1, 4'hF, 10'd1, 32'h0, LD);
`endif
    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
    chk("acc_queue_empty", 32'(acc_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
